// File: rtl/tff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tff_pkg
//  Description : Shared definitions for the T-flip-flop up/down counter:
//                direction encodings and the modulo next-count helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package tff_pkg;

    // Direction encodings for the 'up' input
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Next count for one step in the given direction. Values at or above
    // the modulus only occur from a corrupted state. Such a state steps
    // up to 0 or down to MOD-1, so the count always rejoins the legal range.
    function automatic logic [31:0] next_count(
        input logic [31:0] q,
        input logic        up,
        input logic [31:0] mod_val
    );
        logic [31:0] r;
        if (up == DIR_UP) begin
            r = (q >= mod_val - 32'd1) ? 32'd0 : q + 32'd1;
        end else begin
            r = ((q == 32'd0) || (q >= mod_val)) ? mod_val - 32'd1 : q - 32'd1;
        end
        return r;
    endfunction

    // True when a step from q in direction up wraps around the modulus
    function automatic logic is_wrap(
        input logic [31:0] q,
        input logic        up,
        input logic [31:0] mod_val
    );
        return (up == DIR_UP) ? (q == mod_val - 32'd1) : (q == 32'd0);
    endfunction

    // Value actually loaded: out-of-range requests collapse to 0
    function automatic logic [31:0] load_value(
        input logic [31:0] load_val,
        input logic [31:0] mod_val
    );
        return (load_val < mod_val) ? load_val : 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tff_cell.sv
`default_nettype none
// ============================================================================
//  Module      : tff_cell
//  Description : Single T flip-flop with synchronous active-high reset.
//                The output toggles on a clock edge when t is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic r_q;

    // Toggle storage: clear on reset, otherwise flip when t is set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/tff_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tff_updown_counter
//  Description : Synchronous modulo-MOD up/down counter built entirely from
//                T flip-flop cells. The top computes the next count, derives a
//                per-bit toggle vector from it, and decodes tc and ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module tff_updown_counter #(
    parameter int unsigned W   = 4,
    parameter int unsigned MOD = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         ovf
);

    import tff_pkg::*;

    // Terminal value and modulus in the widths the comparisons need.
    // The modulus may equal 2**W, so it is only ever handled at 32 bits.
    localparam logic [31:0]  c_MOD = 32'(MOD);
    localparam logic [W-1:0] c_MAX = W'(MOD - 1);

    // Reject parameter sets that cannot produce a valid counter
    generate
        if ((W < 2) || (W > 31) || (MOD < 2) || (MOD > (32'd1 << W))) begin : g_bad_params
            $error("tff_updown_counter: unsupported W/MOD combination");
        end
    endgenerate

    logic [W-1:0] w_q;      // current count, read back from the T cells
    logic [W-1:0] w_next;   // count the cells should hold after this edge
    logic [W-1:0] w_t;      // per-bit toggle request
    logic         w_wrap;   // this edge performs a counting wrap
    logic         r_ovf;

    // Next-state selection: load beats count, idle holds the current value
    always_comb begin
        w_next = w_q;
        w_wrap = 1'b0;
        if (load) begin
            w_next = W'(load_value(32'(load_val), c_MOD));
        end else if (en) begin
            w_next = W'(next_count(32'(w_q), up, c_MOD));
            w_wrap = is_wrap(32'(w_q), up, c_MOD);
        end
    end

    // A bit toggles exactly where the current and next counts differ
    assign w_t = w_q ^ w_next;

    generate
        for (genvar i = 0; i < int'(W); i++) begin : g_cell
            tff_cell u_cell (
                .clk (clk),
                .rst (rst),
                .t   (w_t[i]),
                .q   (w_q[i])
            );
        end
    endgenerate

    // Overflow pulse: set for one cycle after a counting wrap, cleared otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_wrap;
        end
    end

    assign q   = w_q;
    assign ovf = r_ovf;
    assign tc  = en & (up ? (w_q == c_MAX) : (w_q == '0));

endmodule
`default_nettype wire

// File: tb/tb_tff_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tff_updown_counter
//  Description : Self-checking bench for tff_updown_counter with modulus-10
//                and modulus-16 instances, a vector table and expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tff_updown_counter;

    import tff_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] q;
    logic       tc, ovf;

    logic       rst2 = 1'b1, en2 = 1'b0, up2 = 1'b0, load2 = 1'b0;
    logic [3:0] load_val2 = 4'd0;
    logic [3:0] q2;
    logic       tc2, ovf2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tff_updown_counter #(.W(4), .MOD(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .ovf(ovf)
    );

    tff_updown_counter #(.W(4), .MOD(16)) dut16 (
        .clk(clk), .rst(rst2), .en(en2), .up(up2), .load(load2),
        .load_val(load_val2), .q(q2), .tc(tc2), .ovf(ovf2)
    );

    typedef struct {
        logic       rst, en, up, ld;
        logic [3:0] lv;
        logic       chk_tc;   // tc compared before the edge
        logic       tc;
        logic       chk_t;    // toggle vector must be zero before the edge
        logic [3:0] q;        // expected after the edge
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [3:0] q;
        logic       ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(int r, int e, int u, int l, int lv,
                                int ctc, int etc, int ct, int eq, int eo);
        vec_t v;
        v.rst = (r != 0);  v.en = (e != 0);  v.up = (u != 0);  v.ld = (l != 0);
        v.lv = 4'(lv);
        v.chk_tc = (ctc != 0);  v.tc = (etc != 0);  v.chk_t = (ct != 0);
        v.q = 4'(eq);  v.ovf = (eo != 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive one vector into the MOD=10 instance and compare after the edge
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        rst = v.rst;  en = v.en;  up = v.up;  load = v.ld;  load_val = v.lv;
        #1;
        if (v.chk_tc) chk($sformatf("tc[%0d]", idx), 32'(tc), 32'(v.tc));
        if (v.chk_t)  chk($sformatf("t_zero[%0d]", idx), 32'(dut.w_t), 32'd0);
        e.q = v.q;  e.ovf = v.ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("q[%0d]", idx), 32'(q), 32'(e.q));
        chk($sformatf("ovf[%0d]", idx), 32'(ovf), 32'(e.ovf));
    endtask

    initial begin
        //                 rst en up ld lv  ctc tc ct  q  ovf
        // reset with load/en active, then count 1,2,3
        vecs.push_back(mk(1, 1, 1, 1, 7,  0, 0, 0,  0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 7,  1, 0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0,  1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0,  2, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0,  3, 0));
        // tc=1 during reset with en=1, up=0
        vecs.push_back(mk(1, 1, 0, 0, 0,  1, 0, 0,  0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,  1, 1, 0,  0, 0));
        // up wrap from 8
        vecs.push_back(mk(0, 0, 1, 1, 8,  1, 0, 0,  8, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0,  9, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 1, 0,  0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0,  1, 0));
        // down wrap from 1
        vecs.push_back(mk(0, 0, 0, 1, 1,  1, 0, 0,  1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0,  9, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0,  8, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0,  7, 0));
        // load priority and range clamping
        vecs.push_back(mk(0, 0, 1, 1, 4,  1, 0, 0,  4, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2,  1, 0, 0,  2, 0));
        vecs.push_back(mk(0, 0, 1, 1, 9,  1, 0, 0,  9, 0));
        vecs.push_back(mk(0, 1, 1, 1, 12, 1, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 3,  1, 0, 0,  3, 0));
        vecs.push_back(mk(0, 0, 1, 1, 10, 1, 0, 0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 5,  1, 0, 0,  5, 0));
        vecs.push_back(mk(1, 0, 1, 1, 5,  1, 0, 0,  0, 0));
        // hold at 6 for 5 cycles, then direction flips
        vecs.push_back(mk(0, 0, 1, 1, 6,  1, 0, 0,  6, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, (i % 2), 0, 0, 1, 0, 1, 6, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0,  7, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0,  6, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0,  7, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0,  6, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Back-to-back wraps: 0 -down-> 9 -up-> 0 -down-> 9, then hold clears ovf
        apply(mk(0, 0, 0, 1, 0,  1, 0, 0,  0, 0), 100);
        apply(mk(0, 1, 0, 0, 0,  1, 1, 0,  9, 1), 101);
        apply(mk(0, 1, 1, 0, 0,  1, 1, 0,  0, 1), 102);
        apply(mk(0, 1, 0, 0, 0,  1, 1, 0,  9, 1), 103);
        apply(mk(0, 0, 0, 0, 0,  1, 0, 1,  9, 0), 104);
        // Reset on a wrapping edge suppresses ovf, counting resumes from 0
        apply(mk(1, 1, 1, 0, 0,  1, 1, 0,  0, 0), 105);
        apply(mk(0, 1, 1, 0, 0,  1, 0, 0,  1, 0), 106);

        // Full-range run on the MOD=16 instance
        begin
            logic [31:0] m;
            int          pulses;
            exp_t        e;
            m = 32'd0;
            pulses = 0;
            @(negedge clk);
            rst2 = 1'b1;  en2 = 1'b1;  up2 = 1'b1;
            @(posedge clk);
            #1;
            chk("full_reset_q", 32'(q2), 32'd0);
            chk("full_reset_ovf", 32'(ovf2), 32'd0);
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                rst2 = 1'b0;  en2 = 1'b1;  up2 = DIR_UP;
                e.q   = 4'(next_count(m, DIR_UP, 32'd16));
                e.ovf = (m == 32'd15);
                sb.push_back(e);
                m = next_count(m, DIR_UP, 32'd16);
                @(posedge clk);
                #1;
                e = sb.pop_front();
                chk($sformatf("full_q[%0d]", k), 32'(q2), 32'(e.q));
                chk($sformatf("full_ovf[%0d]", k), 32'(ovf2), 32'(e.ovf));
                if (ovf2) pulses++;
                if (k == 16 || k == 32) chk($sformatf("full_pulse_at[%0d]", k), 32'(ovf2), 32'd1);
            end
            chk("full_pulse_count", 32'(pulses), 32'd2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
